// File: rtl/de2_i2c_arbiter.sv
// -----------------------------------------------------------------------------
// de2_i2c_arbiter
//
// Shares the single DE2 I2C controller between two transaction requesters
// (typically the power-up configuration sequencer on port 0 and a runtime
// audio control path on port 1). One 24-bit write {slave, sub, data} is
// sequenced at a time. Ties go round-robin, a NACK or a hung controller is
// retried, and every transaction ends with exactly one oDONE pulse.
//
// Parameters
//   MAX_RETRY   extra attempts after a failed attempt (0..7)
//   TIMEOUT     iCLK cycles allowed in each wait state
//   GAP_CYCLES  idle cycles forced between attempts (>= 1)
//
// Ports
//   iCLK       system clock (50 MHz)
//   iRST       synchronous reset, active-high
//   iREQ[1:0]  request level per requester, held until its oDONE
//   iDATA0/1   24-bit transaction per requester, stable while requested
//   oDONE[1:0] one-cycle completion pulse per requester
//   oERR[1:0]  qualifies oDONE: 1 = every attempt failed
//   oBUSY      high in every state except IDLE
//   oOWNER     requester currently being served
//   oI2C_DATA  to controller I2C_DATA
//   oI2C_GO    to controller GO
//   iI2C_END   controller END (high when idle/finished), already on iCLK
//   iI2C_ACK   controller ACK (0 = all bytes acknowledged, 1 = NACK)
// -----------------------------------------------------------------------------
module de2_i2c_arbiter #(
  parameter int          MAX_RETRY  = 3,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF,
  parameter int          GAP_CYCLES = 64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [1:0]  iREQ,
  input  logic [23:0] iDATA0,
  input  logic [23:0] iDATA1,
  output logic [1:0]  oDONE,
  output logic [1:0]  oERR,
  output logic        oBUSY,
  output logic        oOWNER,
  output logic [23:0] oI2C_DATA,
  output logic        oI2C_GO,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK
);

  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);
  localparam int         GAP_W       = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE,
    EVAL,
    GAP
  } stateT;

  stateT            state;
  logic             last;          // requester most recently completed
  logic [2:0]       retryCnt;
  logic [15:0]      timer;
  logic [GAP_W-1:0] gapCnt;
  logic             retryPending;  // GAP must reissue instead of returning to IDLE
  logic             attemptFail;   // NACK or timeout on the current attempt

  logic        winner;
  logic [15:0] timerInc;
  logic        timeoutHit;

  // On a tie the requester that did not finish last wins; otherwise the
  // single active requester wins (iREQ[1] is 1 only when requester 1 asks).
  assign winner     = (iREQ == 2'b11) ? ~last : iREQ[1];

  // Saturating timer, so a huge TIMEOUT can never wrap past its match value.
  assign timerInc   = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  assign timeoutHit = (timer == TIMEOUT);

  // NOTE: every register here is assigned with <= so all state updates see
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      last         <= 1'b1;
      retryCnt     <= '0;
      timer        <= '0;
      gapCnt       <= '0;
      retryPending <= 1'b0;
      attemptFail  <= 1'b0;
      oDONE        <= '0;
      oERR         <= '0;
      oBUSY        <= 1'b0;
      oOWNER       <= 1'b0;
      oI2C_DATA    <= '0;
      oI2C_GO      <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses; EVAL is the only state
      // that raises them.
      oDONE <= '0;
      oERR  <= '0;

      case (state)
        IDLE: begin
          if (|iREQ) begin
            oOWNER       <= winner;
            oI2C_DATA    <= winner ? iDATA1 : iDATA0;
            oI2C_GO      <= 1'b1;
            oBUSY        <= 1'b1;
            retryCnt     <= '0;
            timer        <= '0;
            retryPending <= 1'b0;
            attemptFail  <= 1'b0;
            state        <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (!iI2C_END) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timeoutHit) begin
            // Controller never started: release GO so a retry is a fresh edge.
            oI2C_GO     <= 1'b0;
            attemptFail <= 1'b1;
            state       <= EVAL;
          end else begin
            timer <= timerInc;
          end
        end

        WAIT_DONE: begin
          if (iI2C_END) begin
            oI2C_GO     <= 1'b0;
            attemptFail <= iI2C_ACK;
            state       <= EVAL;
          end else if (timeoutHit) begin
            oI2C_GO     <= 1'b0;
            attemptFail <= 1'b1;
            state       <= EVAL;
          end else begin
            timer <= timerInc;
          end
        end

        EVAL: begin
          gapCnt <= '0;
          state  <= GAP;
          if (!attemptFail) begin
            oDONE[oOWNER] <= 1'b1;
            last          <= oOWNER;
          end else if (retryCnt < MAX_RETRY_C) begin
            retryCnt     <= retryCnt + 3'd1;
            retryPending <= 1'b1;
          end else begin
            oDONE[oOWNER] <= 1'b1;
            oERR[oOWNER]  <= 1'b1;
            last          <= oOWNER;
          end
        end

        GAP: begin
          // The gap also covers the cycle in which a finished requester
          // drops iREQ, so it is never re-sampled as a new request.
          if (gapCnt == GAP_LAST) begin
            gapCnt <= '0;
            if (retryPending) begin
              oI2C_GO      <= 1'b1;
              timer        <= '0;
              attemptFail  <= 1'b0;
              retryPending <= 1'b0;
              state        <= WAIT_START;
            end else begin
              oBUSY <= 1'b0;
              state <= IDLE;
            end
          end else begin
            gapCnt <= gapCnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de2_i2c_arbiter.sv
// -----------------------------------------------------------------------------
// tb_de2_i2c_arbiter
//
// Self-checking bench for de2_i2c_arbiter. A behavioural I2C controller model
// answers GO with an END low pulse and a scripted ACK/NACK sequence (or hangs).
// A monitor logs every GO pulse and every oDONE pulse; each scenario task
// compares those logs with what the arbitration rules predict.
// -----------------------------------------------------------------------------
module tb_de2_i2c_arbiter;

  localparam int TB_MAX_RETRY = 3;
  localparam int TB_TIMEOUT   = 100;
  localparam int TB_GAP       = 64;
  localparam int PERIOD       = 10;

  logic        iCLK;
  logic        iRST;
  logic [1:0]  iREQ;
  logic [23:0] iDATA0;
  logic [23:0] iDATA1;
  logic [1:0]  oDONE;
  logic [1:0]  oERR;
  logic        oBUSY;
  logic        oOWNER;
  logic [23:0] oI2C_DATA;
  logic        oI2C_GO;
  logic        iI2C_END;
  logic        iI2C_ACK;

  de2_i2c_arbiter #(
    .MAX_RETRY  (TB_MAX_RETRY),
    .TIMEOUT    (16'(TB_TIMEOUT)),
    .GAP_CYCLES (TB_GAP)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iREQ      (iREQ),
    .iDATA0    (iDATA0),
    .iDATA1    (iDATA1),
    .oDONE     (oDONE),
    .oERR      (oERR),
    .oBUSY     (oBUSY),
    .oOWNER    (oOWNER),
    .oI2C_DATA (oI2C_DATA),
    .oI2C_GO   (oI2C_GO),
    .iI2C_END  (iI2C_END),
    .iI2C_ACK  (iI2C_ACK)
  );

  initial begin
    iCLK = 1'b0;
    forever #(PERIOD / 2) iCLK = ~iCLK;
  end

  int checks = 0;
  int errors = 0;

  // Observation logs
  logic [23:0] goData[$];
  logic        goOwn[$];
  time         goTime[$];
  int          goLen[$];
  logic        doneReq[$];
  logic        doneErr[$];
  time         doneTime[$];
  time         endRiseTime;

  // Controller model / requester behaviour knobs
  bit autoDrop    = 1'b1;
  bit ctrlHang    = 1'b0;
  int ctrlLow     = 20;
  int ctrlNacks   = 0;
  int ctrlAttempt = 0;

  // Monitor: logs GO pulses and completions, drops a finished request.
  initial begin
    logic prevGo;
    int   runLen;
    prevGo = 1'b0;
    runLen = 0;
    forever begin
      @(negedge iCLK);
      if (oI2C_GO) begin
        if (!prevGo) begin
          goData.push_back(oI2C_DATA);
          goOwn.push_back(oOWNER);
          goTime.push_back($time);
          runLen = 0;
        end
        runLen++;
      end else if (prevGo) begin
        goLen.push_back(runLen);
      end
      prevGo = oI2C_GO;
      for (int i = 0; i < 2; i++) begin
        if (oDONE[i]) begin
          doneReq.push_back(i[0]);
          doneErr.push_back(oERR[i]);
          doneTime.push_back($time);
          ctrlAttempt = 0;
          if (autoDrop) iREQ[i] = 1'b0;
        end
      end
      checks++;
      if ((oERR & ~oDONE) != 2'b00) begin
        errors++;
        $display("FAIL err_without_done oERR=%b oDONE=%b", oERR, oDONE);
      end
    end
  end

  // Behavioural DE2 I2C controller: END falls shortly after GO, stays low
  // ctrlLow cycles, then rises with ACK=1 for the first ctrlNacks attempts.
  initial begin
    iI2C_END = 1'b1;
    iI2C_ACK = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oI2C_GO && !ctrlHang && !iRST) begin
        repeat (2) @(negedge iCLK);
        iI2C_END = 1'b0;
        for (int t = 0; t < ctrlLow && !iRST; t++) @(negedge iCLK);
        iI2C_ACK = (ctrlAttempt < ctrlNacks);
        ctrlAttempt++;
        iI2C_END = 1'b1;
        endRiseTime = $time;
        for (int t = 0; t < 8 && oI2C_GO; t++) @(negedge iCLK);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clearLogs();
    goData.delete();
    goOwn.delete();
    goTime.delete();
    goLen.delete();
    doneReq.delete();
    doneErr.delete();
    doneTime.delete();
  endtask

  task automatic doReset();
    @(negedge iCLK);
    #1;
    iRST = 1'b1;
    iREQ = 2'b00;
    repeat (2) @(negedge iCLK);
    #1;
    iRST = 1'b0;
    ctrlAttempt = 0;
  endtask

  task automatic waitDones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iCLK);
      #1;
      if (doneReq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iCLK);
      #1;
      if (!oBUSY && iREQ == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    iREQ = 2'b00;
    iDATA0 = '0;
    iDATA1 = '0;
    repeat (3) @(negedge iCLK);
    #1;
    checks++;
    if (oI2C_GO !== 1'b0 || oI2C_DATA !== 24'h0) begin
      errors++;
      $display("FAIL reset_i2c go=%b data=%h expected go=0 data=000000", oI2C_GO, oI2C_DATA);
    end
    checks++;
    if (oDONE !== 2'b00 || oERR !== 2'b00) begin
      errors++;
      $display("FAIL reset_done done=%b err=%b expected 00/00", oDONE, oERR);
    end
    checks++;
    if (oBUSY !== 1'b0 || oOWNER !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%b owner=%b expected 0/0", oBUSY, oOWNER);
    end
    iRST = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    clearLogs();
    ctrlLow = 60;
    ctrlNacks = 0;
    ctrlAttempt = 0;
    @(negedge iCLK);
    #1;
    iDATA0 = 24'h34001A;
    iREQ = 2'b01;
    @(negedge iCLK);
    #1;
    checks++;
    if (oI2C_GO !== 1'b1 || oI2C_DATA !== 24'h34001A || oOWNER !== 1'b0) begin
      errors++;
      $display("FAIL single_issue go=%b data=%h owner=%b expected 1/34001a/0", oI2C_GO, oI2C_DATA, oOWNER);
    end
    waitDones(1, 500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done_timeout dones=%0d expected 1", doneReq.size());
    end else begin
      checks++;
      if (doneReq[0] !== 1'b0 || doneErr[0] !== 1'b0 || goData.size() != 1) begin
        errors++;
        $display("FAIL single_result req=%b err=%b gos=%0d expected 0/0/1", doneReq[0], doneErr[0], goData.size());
      end
      checks++;
      if (doneTime[0] - endRiseTime != 2 * PERIOD) begin
        errors++;
        $display("FAIL single_done_latency got=%0t expected=%0t", doneTime[0] - endRiseTime, 2 * PERIOD);
      end
      repeat (TB_GAP - 1) @(negedge iCLK);
      #1;
      checks++;
      if (oBUSY !== 1'b1) begin
        errors++;
        $display("FAIL single_busy_in_gap busy=%b expected 1", oBUSY);
      end
      @(negedge iCLK);
      #1;
      checks++;
      if (oBUSY !== 1'b0) begin
        errors++;
        $display("FAIL single_busy_after_gap busy=%b expected 0", oBUSY);
      end
    end
  endtask

  task automatic test_tie();
    bit ok;
    logic [23:0] d0, d1;
    logic        exp;
    doReset();
    clearLogs();
    autoDrop = 1'b0;
    ctrlNacks = 0;
    ctrlLow = $urandom_range(5, 40);
    d0 = 24'($urandom);
    d1 = d0 ^ 24'h800001;
    iDATA0 = d0;
    iDATA1 = d1;
    iREQ = 2'b11;
    waitDones(4, 2000, ok);
    iREQ = 2'b00;
    autoDrop = 1'b1;
    checks++;
    if (!ok || goData.size() < 4) begin
      errors++;
      $display("FAIL tie_timeout dones=%0d gos=%0d expected 4/4", doneReq.size(), goData.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp = k[0];
        checks++;
        if (doneReq[k] !== exp || goOwn[k] !== exp || goData[k] !== (exp ? d1 : d0) || doneErr[k] !== 1'b0) begin
          errors++;
          $display("FAIL tie_order k=%0d done=%b owner=%b data=%h expected %b/%b/%h", k, doneReq[k], goOwn[k], goData[k], exp, exp, exp ? d1 : d0);
        end
        if (k > 0) begin
          checks++;
          if (goTime[k] - doneTime[k-1] < (TB_GAP + 1) * PERIOD) begin
            errors++;
            $display("FAIL tie_spacing k=%0d got=%0t min=%0t", k, goTime[k] - doneTime[k-1], (TB_GAP + 1) * PERIOD);
          end
        end
      end
    end
    waitIdle(200, ok);
  endtask

  task automatic test_nack_then_success();
    bit ok;
    logic [23:0] d1;
    bit allSame;
    waitIdle(500, ok);
    clearLogs();
    ctrlNacks = 2;
    ctrlAttempt = 0;
    ctrlLow = 15;
    d1 = 24'($urandom);
    iDATA1 = d1;
    iREQ = 2'b10;
    waitDones(1, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nack_ok_timeout dones=%0d expected 1", doneReq.size());
    end else begin
      allSame = 1'b1;
      foreach (goData[g]) if (goData[g] !== d1) allSame = 1'b0;
      checks++;
      if (goData.size() != 3 || !allSame) begin
        errors++;
        $display("FAIL nack_ok_attempts gos=%0d same=%b expected 3/1", goData.size(), allSame);
      end
      checks++;
      if (doneReq.size() != 1 || doneReq[0] !== 1'b1 || doneErr[0] !== 1'b0) begin
        errors++;
        $display("FAIL nack_ok_result n=%0d req=%b err=%b expected 1/1/0", doneReq.size(), doneReq[0], doneErr[0]);
      end
    end
  endtask

  task automatic test_persistent_nack();
    bit ok;
    waitIdle(500, ok);
    clearLogs();
    ctrlNacks = 99;
    ctrlAttempt = 0;
    ctrlLow = 10;
    iDATA0 = 24'($urandom);
    iREQ = 2'b01;
    waitDones(1, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nack_err_timeout dones=%0d expected 1", doneReq.size());
    end else begin
      checks++;
      if (goData.size() != TB_MAX_RETRY + 1 || doneReq[0] !== 1'b0 || doneErr[0] !== 1'b1) begin
        errors++;
        $display("FAIL nack_err_result gos=%0d req=%b err=%b expected %0d/0/1", goData.size(), doneReq[0], doneErr[0], TB_MAX_RETRY + 1);
      end
    end
    waitIdle(500, ok);
    clearLogs();
    ctrlNacks = 0;
    ctrlAttempt = 0;
    iDATA1 = 24'($urandom);
    iREQ = 2'b10;
    waitDones(1, 1000, ok);
    checks++;
    if (!ok || goData.size() != 1 || doneReq[0] !== 1'b1 || doneErr[0] !== 1'b0) begin
      errors++;
      $display("FAIL nack_recover ok=%b gos=%0d expected served once without error", ok, goData.size());
    end
  endtask

  task automatic test_hang();
    bit ok;
    bit lenOk;
    waitIdle(500, ok);
    clearLogs();
    ctrlHang = 1'b1;
    iDATA0 = 24'($urandom);
    iREQ = 2'b01;
    waitDones(1, 3000, ok);
    ctrlHang = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hang_timeout dones=%0d expected 1", doneReq.size());
    end else begin
      lenOk = 1'b1;
      foreach (goLen[g]) if (goLen[g] < TB_TIMEOUT || goLen[g] > TB_TIMEOUT + 2) lenOk = 1'b0;
      checks++;
      if (goLen.size() != TB_MAX_RETRY + 1 || !lenOk) begin
        errors++;
        $display("FAIL hang_attempts gos=%0d len_ok=%b expected %0d pulses of ~%0d cycles", goLen.size(), lenOk, TB_MAX_RETRY + 1, TB_TIMEOUT);
      end
      checks++;
      if (doneReq[0] !== 1'b0 || doneErr[0] !== 1'b1) begin
        errors++;
        $display("FAIL hang_result req=%b err=%b expected 0/1", doneReq[0], doneErr[0]);
      end
    end
  endtask

  // Randomized transactions checked against the arbitration rules.
  task automatic test_random();
    bit ok;
    logic refLast;
    logic ordr[2];
    int   ns, n, att;
    logic expErr;
    logic [1:0] p;
    logic [23:0] d0, d1;
    doReset();
    refLast = 1'b1;
    for (int it = 0; it < 10; it++) begin
      waitIdle(2000, ok);
      clearLogs();
      p  = 2'($urandom_range(1, 3));
      d0 = 24'($urandom);
      d1 = 24'($urandom);
      n  = $urandom_range(0, 5);
      ctrlNacks = n;
      ctrlAttempt = 0;
      ctrlLow = $urandom_range(3, 60);
      if (p == 2'b11) begin
        ordr[0] = ~refLast;
        ordr[1] = refLast;
        ns = 2;
      end else begin
        ordr[0] = (p == 2'b10);
        ordr[1] = 1'b0;
        ns = 1;
      end
      att    = (n < TB_MAX_RETRY + 1) ? n + 1 : TB_MAX_RETRY + 1;
      expErr = (n > TB_MAX_RETRY);
      iDATA0 = d0;
      iDATA1 = d1;
      iREQ = p;
      waitDones(ns, 5000, ok);
      checks++;
      if (!ok || goData.size() != ns * att) begin
        errors++;
        $display("FAIL rand_count it=%0d dones=%0d gos=%0d expected %0d/%0d", it, doneReq.size(), goData.size(), ns, ns * att);
      end else begin
        for (int k = 0; k < ns; k++) begin
          checks++;
          if (doneReq[k] !== ordr[k] || doneErr[k] !== expErr) begin
            errors++;
            $display("FAIL rand_done it=%0d k=%0d req=%b err=%b expected %b/%b", it, k, doneReq[k], doneErr[k], ordr[k], expErr);
          end
        end
        for (int g = 0; g < ns * att; g++) begin
          checks++;
          if (goOwn[g] !== ordr[g / att] || goData[g] !== (ordr[g / att] ? d1 : d0)) begin
            errors++;
            $display("FAIL rand_go it=%0d g=%0d owner=%b data=%h expected %b/%h", it, g, goOwn[g], goData[g], ordr[g / att], ordr[g / att] ? d1 : d0);
          end
        end
      end
      refLast = ordr[ns - 1];
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    waitIdle(2000, ok);
    clearLogs();
    ctrlNacks = 0;
    ctrlAttempt = 0;
    ctrlLow = 60;
    iDATA0 = 24'h5A_A5C3;
    iREQ = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge iCLK);
      #1;
      if (!iI2C_END) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_no_start end=%b expected 0", iI2C_END);
    end
    repeat (5) @(negedge iCLK);
    #1;
    iRST = 1'b1;
    iREQ = 2'b00;
    @(negedge iCLK);
    #1;
    checks++;
    if (oI2C_GO !== 1'b0 || oI2C_DATA !== 24'h0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs go=%b data=%h busy=%b expected 0/000000/0", oI2C_GO, oI2C_DATA, oBUSY);
    end
    checks++;
    if (oDONE !== 2'b00 || oERR !== 2'b00 || oOWNER !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags done=%b err=%b owner=%b expected 00/00/0", oDONE, oERR, oOWNER);
    end
    iRST = 1'b0;
    ctrlAttempt = 0;
    repeat (150) @(negedge iCLK);
    #1;
    checks++;
    if (doneReq.size() != 0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done dones=%0d busy=%b expected 0/0", doneReq.size(), oBUSY);
    end
  endtask

  task automatic test_drop_req();
    bit ok;
    waitIdle(500, ok);
    clearLogs();
    ctrlNacks = 1;
    ctrlAttempt = 0;
    ctrlLow = 30;
    iDATA1 = 24'($urandom);
    iREQ = 2'b10;
    repeat (10) @(negedge iCLK);
    #1;
    iREQ = 2'b00;
    waitDones(1, 1000, ok);
    checks++;
    if (!ok || doneReq[0] !== 1'b1 || doneErr[0] !== 1'b0 || goData.size() != 2) begin
      errors++;
      $display("FAIL drop_req ok=%b gos=%0d expected completion after 2 attempts", ok, goData.size());
    end
  endtask

  initial begin
    iREQ   = 2'b00;
    iRST   = 1'b1;
    iDATA0 = '0;
    iDATA1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_nack_then_success();
    test_persistent_nack();
    test_hang();
    test_random();
    test_reset_mid();
    test_drop_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
